// File: rtl/mmio_master_pkg.sv
// mmio_master_pkg: shared constants, FSM encoding and window decode for the MMIO bus initiator.
package mmio_master_pkg;

    localparam logic [15:0] MMIO_BASE        = 16'hFF00;
    localparam logic [15:0] LED_WR_ADDR      = 16'hFF00;
    localparam logic [15:0] UART_DATA_ADDR   = 16'hFF02;
    localparam logic [15:0] UART_STATUS_ADDR = 16'hFF03;

    typedef enum logic [1:0] {
        MM_IDLE  = 2'd0,
        MM_ISSUE = 2'd1,
        MM_WAIT  = 2'd2,
        MM_RESP  = 2'd3
    } mm_state_t;

    function automatic logic in_window(input logic [15:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/mmio_timeout.sv
// mmio_timeout: cycle counter with clear/enable that flags when TIMEOUT cycles have elapsed.
module mmio_timeout
    import mmio_master_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign done = count == TO_W'(TIMEOUT);

endmodule

// File: rtl/mmio_master.sv
// mmio_master: CPU-side initiator for the 0xFF00-0xFFFF MMIO window; issues one bus cycle per
// request, waits for serviced_read on loads, and reports window misses and timeouts as errors.
module mmio_master
    import mmio_master_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  err_count,
    output logic        bus_en,
    output logic        bus_we,
    output logic        bus_byte_select,
    output logic        bus_byte_enable,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        serviced_read
);

    mm_state_t state;
    logic      wr;
    logic      done;
    logic      accept;

    assign req_ready = (state == MM_IDLE) || (state == MM_RESP);
    assign accept    = req_valid && req_ready;

    // Cleared at acceptance and counting through ISSUE, so done lands on the TIMEOUT-th WAIT cycle.
    mmio_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   ((state == MM_ISSUE) || (state == MM_WAIT)),
        .done (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= MM_IDLE;
            wr              <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_err        <= 1'b0;
            err_count       <= '0;
            bus_en          <= 1'b0;
            bus_we          <= 1'b0;
            bus_byte_select <= 1'b0;
            bus_byte_enable <= 1'b0;
            bus_addr        <= '0;
            bus_wdata       <= '0;
        end else begin
            bus_en     <= 1'b0;
            bus_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (resp_valid && resp_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            unique case (state)
                MM_IDLE, MM_RESP: begin
                    state <= MM_IDLE;
                    if (req_valid) begin
                        wr              <= req_write;
                        bus_addr        <= {1'b0, req_addr[15:1]};
                        bus_byte_select <= req_addr[0];
                        bus_byte_enable <= req_byte;
                        bus_wdata       <= req_wdata;
                        if (in_window(req_addr)) begin
                            state  <= MM_ISSUE;
                            bus_en <= 1'b1;
                            bus_we <= req_write;
                        end else begin
                            state      <= MM_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                MM_ISSUE: begin
                    state      <= wr ? MM_RESP : MM_WAIT;
                    resp_valid <= wr;
                end
                MM_WAIT: begin
                    if (serviced_read) begin
                        state      <= MM_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= bus_byte_enable ? {8'h00, bus_rdata[7:0]} : bus_rdata;
                    end else if (done) begin
                        state      <= MM_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// tb_mmio_master: directed checks of mmio_master against a registered stub responder
// (LED word at 0xFF00, UART status byte at 0xFF03) with programmable read-strobe delay.
module tb_mmio_master;
    import mmio_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  err_count;
    logic        bus_en;
    logic        bus_we;
    logic        bus_byte_select;
    logic        bus_byte_enable;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata = '0;
    logic        serviced_read = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_master #(.TIMEOUT(8), .TO_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_byte        (req_byte),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .err_count       (err_count),
        .bus_en          (bus_en),
        .bus_we          (bus_we),
        .bus_byte_select (bus_byte_select),
        .bus_byte_enable (bus_byte_enable),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .serviced_read   (serviced_read)
    );

    // Stub responder: rd_delay = k strobes in WAIT cycle k+1; negative withholds the strobe.
    int          rd_delay = 0;
    int          pend = 0;
    logic [15:0] led = '0;
    logic [15:0] rd_addr = '0;
    int          rv_cnt = 0;

    function automatic logic [15:0] rd_value(input logic [15:0] a);
        if (a == LED_WR_ADDR) return led;
        if (a == UART_STATUS_ADDR) return 16'hEE81;
        return 16'hDEAD;
    endfunction

    always @(posedge clk) begin
        serviced_read <= 1'b0;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (bus_en && bus_we && {bus_addr[14:0], bus_byte_select} == LED_WR_ADDR)
            led <= bus_wdata;
        if (bus_en && !bus_we) begin
            rd_addr <= {bus_addr[14:0], bus_byte_select};
            pend    <= 0;
            if (rd_delay == 0) begin
                serviced_read <= 1'b1;
                bus_rdata     <= rd_value({bus_addr[14:0], bus_byte_select});
            end else if (rd_delay > 0) begin
                pend <= rd_delay;
            end
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                serviced_read <= 1'b1;
                bus_rdata     <= rd_value(rd_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int          lat, en_cnt;
    logic        last_we, last_bsel;
    logic [15:0] last_addr, rd;
    logic        er;

    // Issue one request from idle and watch it until resp_valid (bounded).
    task automatic xfer(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; en_cnt = 0;
        while (1) begin
            if (bus_en) begin
                en_cnt++; last_we = bus_we; last_addr = bus_addr; last_bsel = bus_byte_select;
            end
            if (resp_valid || lat > 40) break;
            @(posedge clk); #1;
            lat++;
        end
        check("resp_within_bound", 32'(lat <= 40), 32'd1);
        rd = resp_rdata; er = resp_err;
    endtask

    initial begin
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_bus_en", 32'(bus_en), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // T1 LED store
        xfer(1'b1, 1'b0, 16'hFF00, 16'h00A5);
        check("t1_latency", lat, 2);
        check("t1_en_cycles", en_cnt, 1);
        check("t1_we", 32'(last_we), 32'd1);
        check("t1_err", 32'(er), 32'd0);
        check("t1_rdata", 32'(rd), 32'd0);
        check("t1_led", 32'(led), 32'h00A5);

        // T2 LED read-back
        xfer(1'b0, 1'b0, 16'hFF00, 16'h0000);
        check("t2_latency", lat, 3);
        check("t2_we", 32'(last_we), 32'd0);
        check("t2_rdata", 32'(rd), 32'h00A5);
        check("t2_err", 32'(er), 32'd0);

        // T3 UART status byte
        xfer(1'b0, 1'b1, 16'hFF03, 16'h0000);
        check("t3_bus_addr", 32'(last_addr), 32'h7F81);
        check("t3_byte_select", 32'(last_bsel), 32'd1);
        check("t3_rdata", 32'(rd), 32'h0081);
        check("t3_latency", lat, 3);

        // T4 window misses, including the address just below the window
        xfer(1'b0, 1'b0, 16'h1234, 16'h0000);
        check("t4_latency", lat, 1);
        check("t4_en_cycles", en_cnt, 0);
        check("t4_err", 32'(er), 32'd1);
        check("t4_rdata", 32'(rd), 32'd0);
        @(posedge clk); #1;
        check("t4_err_count", 32'(err_count), 32'd1);
        xfer(1'b1, 1'b0, 16'hFEFF, 16'h1111);
        check("t4_below_err", 32'(er), 32'd1);
        check("t4_below_en", en_cnt, 0);
        check("t4_below_led", 32'(led), 32'h00A5);

        // T5 timeout, delayed strobe, and strobe coinciding with timeout
        rd_delay = -1;
        xfer(1'b0, 1'b0, 16'hFF00, 16'h0000);
        check("t5_timeout_latency", lat, 10);
        check("t5_timeout_err", 32'(er), 32'd1);
        check("t5_timeout_rdata", 32'(rd), 32'd0);
        @(posedge clk); #1;
        check("t5_err_count", 32'(err_count), 32'd3);
        rd_delay = 2;
        xfer(1'b0, 1'b0, 16'hFF00, 16'h0000);
        check("t5_delay_latency", lat, 5);
        check("t5_delay_rdata", 32'(rd), 32'h00A5);
        rd_delay = 7;
        xfer(1'b0, 1'b0, 16'hFF00, 16'h0000);
        check("t5_tie_latency", lat, 10);
        check("t5_tie_err", 32'(er), 32'd0);
        check("t5_tie_rdata", 32'(rd), 32'h00A5);
        rd_delay = 0;

        // T6 overlap: store then load accepted in the store's RESP cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 16'hFF00; req_wdata = 16'h0011;
        @(posedge clk); #1;
        req_write = 1'b0; req_wdata = 16'h0000;
        check("t6_issue_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("t6_store_resp", 32'({resp_valid, resp_err, req_ready}), 32'b101);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t6_load_issue", 32'({bus_en, bus_we, resp_valid}), 32'b100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_load_resp", 32'({resp_valid, resp_err}), 32'b10);
        check("t6_load_rdata", 32'(resp_rdata), 32'h0011);

        // Reset during WAIT abandons the load silently
        rd_delay = -1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'hFF00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(req_ready), 32'd1);
        check("t6_rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rv_cnt = 0;
        rd_delay = 0;
        repeat (15) @(posedge clk);
        #1;
        check("t6_rst_no_resp", rv_cnt, 0);

        // 256 back-to-back misses saturate err_count
        @(negedge clk);
        rv_cnt = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
        repeat (256) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_miss_resp_count", rv_cnt, 256);
        check("t6_err_sat", 32'(err_count), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
